ballot_console: RTL and testbench

Voter-side front end for the tally counters. It collects a multi-digit PIN from a keypad and checks it against the stored reference PIN. After a match it accepts one candidate selection and delivers it to the tally block as a one-hot vote over a valid/ready handshake. It also enforces lockout after repeated PIN failures, aborts idle sessions on timeout, and keeps a running count of delivered votes.

---
 rtl/ballot_pkg.sv | 20 ++
 rtl/pin_matcher.sv | 23 ++
 rtl/ballot_console.sv | 178 +++++++++++++++++
 tb/tb_ballot_console.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ballot_pkg.sv
// Shared types and default sizing for the ballot console front end.
package ballot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PIN,
    CHECK,
    SELECT,
    SEND,
    LOCKED
  } state_e;

  localparam int DEF_PIN_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_N_CAND     = 4;
  localparam int DEF_MAX_TRIES  = 3;
  localparam int DEF_TIMEOUT    = 255;
  localparam int VOTES_W        = 8;

endpackage

// File: rtl/pin_matcher.sv
// Combinational comparison of the collected PIN digits against the reference PIN.
module pin_matcher
  import ballot_pkg::*;
#(
  parameter int PIN_DIGITS = DEF_PIN_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W
) (
  input  logic [PIN_DIGITS*DIGIT_W-1:0] slots_i,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_ref_i,
  output logic                          match_o
);

  logic [PIN_DIGITS-1:0] digit_eq;

  always_comb begin
    digit_eq = '0;
    for (int i = 0; i < PIN_DIGITS; i++) begin
      digit_eq[i] = (slots_i[i*DIGIT_W +: DIGIT_W] == pin_ref_i[i*DIGIT_W +: DIGIT_W]);
    end
    match_o = &digit_eq;
  end

endmodule

// File: rtl/ballot_console.sv
// Voter front end: PIN entry and check, lockout, candidate selection and one-hot vote
// delivery to the tally block over valid/ready, with idle timeout and a vote counter.
module ballot_console
  import ballot_pkg::*;
#(
  parameter int PIN_DIGITS = DEF_PIN_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int N_CAND     = DEF_N_CAND,
  parameter int MAX_TRIES  = DEF_MAX_TRIES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_digit,
  input  logic [PIN_DIGITS*DIGIT_W-1:0] pin_ref,
  input  logic                          sel_valid,
  input  logic [$clog2(N_CAND)-1:0]     sel_cand,
  input  logic                          unlock,
  output logic                          vote_valid,
  output logic [N_CAND-1:0]             vote_onehot,
  input  logic                          vote_ready,
  output logic                          auth_ok,
  output logic                          locked,
  output logic                          err,
  output logic [VOTES_W-1:0]            votes_cast
);

  localparam int SEL_W  = $clog2(N_CAND);
  localparam int CNT_W  = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(PIN_DIGITS - 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

  state_e                             state_q, state_d;
  logic [PIN_DIGITS-1:0][DIGIT_W-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic [FAIL_W-1:0]                  fail_q, fail_d;
  logic [IDLE_W-1:0]                  idle_q, idle_d;
  logic [SEL_W-1:0]                   cand_q, cand_d;
  logic [VOTES_W-1:0]                 votes_q, votes_d;
  logic                               err_q, err_d;
  logic                               vote_valid_q, auth_ok_q, locked_q;
  logic [N_CAND-1:0]                  vote_onehot_q;

  logic pin_match;
  logic sel_in_range;
  logic handshake;
  logic any_input;
  logic timed_out;

  pin_matcher #(
    .PIN_DIGITS(PIN_DIGITS),
    .DIGIT_W   (DIGIT_W)
  ) u_pin_matcher (
    .slots_i  (slots_q),
    .pin_ref_i(pin_ref),
    .match_o  (pin_match)
  );

  assign sel_in_range = ({1'b0, sel_cand} < (SEL_W+1)'(N_CAND));
  assign handshake    = vote_valid_q & vote_ready;
  assign any_input    = key_valid | sel_valid;
  assign timed_out    = !any_input && (idle_q == TIMEOUT_V);

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    count_d = count_q;
    fail_d  = fail_q;
    cand_d  = cand_q;
    votes_d = votes_q;
    err_d   = 1'b0;
    idle_d  = '0;

    // The idle counter only runs while waiting on the voter.
    if ((state_q == PIN) || (state_q == SELECT)) begin
      idle_d = any_input ? '0 : idle_q + IDLE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          slots_d[0] = key_digit;
          count_d    = CNT_W'(1);
          state_d    = (PIN_DIGITS == 1) ? CHECK : PIN;
        end
      end
      PIN: begin
        if (key_valid) begin
          slots_d[count_q] = key_digit;
          count_d          = count_q + CNT_W'(1);
          if (count_q == LAST_SLOT) state_d = CHECK;
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      CHECK: begin
        if (pin_match) begin
          fail_d  = '0;
          state_d = SELECT;
        end else begin
          fail_d  = fail_q + FAIL_W'(1);
          err_d   = 1'b1;
          state_d = (fail_d >= FAIL_W'(MAX_TRIES)) ? LOCKED : IDLE;
        end
      end
      SELECT: begin
        if (sel_valid && sel_in_range) begin
          cand_d  = sel_cand;
          state_d = SEND;
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      SEND: begin
        if (handshake) begin
          state_d = IDLE;
          if (votes_q != '1) votes_d = votes_q + VOTES_W'(1);
        end
      end
      LOCKED: begin
        if (unlock) begin
          fail_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Digits only survive while a PIN is being entered or checked.
    if ((state_d != PIN) && (state_d != CHECK)) begin
      slots_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slots_q       <= '0;
      count_q       <= '0;
      fail_q        <= '0;
      idle_q        <= '0;
      cand_q        <= '0;
      votes_q       <= '0;
      err_q         <= 1'b0;
      vote_valid_q  <= 1'b0;
      vote_onehot_q <= '0;
      auth_ok_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slots_q       <= slots_d;
      count_q       <= count_d;
      fail_q        <= fail_d;
      idle_q        <= idle_d;
      cand_q        <= cand_d;
      votes_q       <= votes_d;
      err_q         <= err_d;
      vote_valid_q  <= (state_d == SEND);
      vote_onehot_q <= (state_d == SEND) ? (N_CAND'(1) << cand_d) : '0;
      auth_ok_q     <= (state_d == SELECT);
      locked_q      <= (state_d == LOCKED);
    end
  end

  assign vote_valid  = vote_valid_q;
  assign vote_onehot = vote_onehot_q;
  assign auth_ok     = auth_ok_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign votes_cast  = votes_q;

endmodule

// File: tb/tb_ballot_console.sv
// Scoreboard bench for ballot_console: directed sessions push expected votes, monitors pop on handshake.
module tb_ballot_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        keyValid = 1'b0;
  logic [3:0]  keyDigit = '0;
  logic [15:0] pinRef = 16'h4321;
  logic        selValid = 1'b0;
  logic [1:0]  selCand = '0;
  logic        unlock = 1'b0;
  logic        voteValid;
  logic [3:0]  voteOnehot;
  logic        voteReady = 1'b0;
  logic        authOk, locked, err;
  logic [7:0]  votesCast;

  logic        keyValidB = 1'b0;
  logic [3:0]  keyDigitB = '0;
  logic        selValidB = 1'b0;
  logic [2:0]  selCandB = '0;
  logic        unlockB = 1'b0;
  logic        voteReadyB = 1'b1;
  logic        voteValidB;
  logic [4:0]  voteOnehotB;
  logic        authOkB, lockedB, errB;
  logic [7:0]  votesCastB;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  expQ[$];
  logic [4:0]  expQB[$];
  logic [3:0]  expA;
  logic [4:0]  expB;
  logic [15:0] goodPin = 16'h4321;
  logic [15:0] wrongPin = 16'h1111;

  ballot_console dut (
    .clk(clk), .rst_n(rst_n), .key_valid(keyValid), .key_digit(keyDigit), .pin_ref(pinRef),
    .sel_valid(selValid), .sel_cand(selCand), .unlock(unlock), .vote_valid(voteValid),
    .vote_onehot(voteOnehot), .vote_ready(voteReady), .auth_ok(authOk), .locked(locked),
    .err(err), .votes_cast(votesCast)
  );

  ballot_console #(.N_CAND(5)) dutB (
    .clk(clk), .rst_n(rst_n), .key_valid(keyValidB), .key_digit(keyDigitB), .pin_ref(pinRef),
    .sel_valid(selValidB), .sel_cand(selCandB), .unlock(unlockB), .vote_valid(voteValidB),
    .vote_onehot(voteOnehotB), .vote_ready(voteReadyB), .auth_ok(authOkB), .locked(lockedB),
    .err(errB), .votes_cast(votesCastB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [3:0] d);
    keyValid = 1'b1;
    keyDigit = d;
    tick();
    keyValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] pin);
    for (int i = 0; i < 4; i++) pressKey(pin[i*4 +: 4]);
  endtask

  task automatic selectCand(input logic [1:0] c);
    selValid = 1'b1;
    selCand  = c;
    tick();
    selValid = 1'b0;
  endtask

  task automatic doVote(input logic [1:0] c);
    logic [3:0] oh;
    oh = 4'b0001 << c;
    applyStimulus(goodPin);
    tick();
    expQ.push_back(oh);
    selectCand(c);
    tick();
  endtask

  // A vote is consumed on the handshake cycle; one without a queued expectation is spurious.
  always @(negedge clk) begin
    if (rst_n && voteValid && voteReady) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_vote actual=%0h expected=none", voteOnehot);
      end else begin
        expA = expQ.pop_front();
        if (voteOnehot !== expA) begin
          errors++;
          $display("[TB] FAIL vote_onehot actual=%0h expected=%0h", voteOnehot, expA);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && voteValidB && voteReadyB) begin
      checks++;
      if (expQB.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_vote_b actual=%0h expected=none", voteOnehotB);
      end else begin
        expB = expQB.pop_front();
        if (voteOnehotB !== expB) begin
          errors++;
          $display("[TB] FAIL vote_onehot_b actual=%0h expected=%0h", voteOnehotB, expB);
        end
      end
    end
  end

  initial begin
    #3;
    checkOutput("rst_vote_valid", 32'(voteValid), 0);
    checkOutput("rst_vote_onehot", 32'(voteOnehot), 0);
    checkOutput("rst_auth_ok", 32'(authOk), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_votes_cast", 32'(votesCast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Normal vote with a slow tally block.
    applyStimulus(goodPin);
    tick();
    checkOutput("auth_after_pin", 32'(authOk), 1);
    checkOutput("err_after_good_pin", 32'(err), 0);
    expQ.push_back(4'b0100);
    selectCand(2'd2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("send_valid_hold", 32'(voteValid), 1);
      checkOutput("send_onehot_hold", 32'(voteOnehot), 32'h4);
      tick();
    end
    voteReady = 1'b1;
    tick();
    checkOutput("votes_after_first", 32'(votesCast), 1);
    checkOutput("valid_after_handshake", 32'(voteValid), 0);
    checkOutput("auth_after_handshake", 32'(authOk), 0);

    // Lockout after three failures, then unlock.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(wrongPin);
      tick();
      checkOutput("lock_err_pulse", 32'(err), 1);
      checkOutput("lock_locked", 32'(locked), (k == 2) ? 1 : 0);
      tick();
      checkOutput("lock_err_width", 32'(err), 0);
    end
    applyStimulus(goodPin);
    tick();
    checkOutput("locked_ignores_pin", 32'(locked), 1);
    checkOutput("locked_no_auth", 32'(authOk), 0);
    checkOutput("locked_no_err", 32'(err), 0);
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    checkOutput("unlock_clears", 32'(locked), 0);
    applyStimulus(goodPin);
    tick();
    checkOutput("auth_after_unlock", 32'(authOk), 1);
    expQ.push_back(4'b0001);
    selectCand(2'd0);
    tick();
    checkOutput("votes_after_second", 32'(votesCast), 2);

    // Timeout during PIN entry keeps the failure count.
    applyStimulus(wrongPin);
    tick();
    checkOutput("fail_one_err", 32'(err), 1);
    tick();
    pressKey(4'd1);
    pressKey(4'd2);
    repeat (255) tick();
    checkOutput("pin_no_early_timeout", 32'(err), 0);
    tick();
    checkOutput("pin_timeout_err", 32'(err), 1);
    checkOutput("pin_timeout_auth", 32'(authOk), 0);
    tick();
    checkOutput("pin_timeout_err_width", 32'(err), 0);
    applyStimulus(wrongPin);
    tick();
    checkOutput("fail_two_err", 32'(err), 1);
    checkOutput("fail_two_unlocked", 32'(locked), 0);
    tick();
    applyStimulus(wrongPin);
    tick();
    checkOutput("fail_three_locked", 32'(locked), 1);
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    checkOutput("unlock_again", 32'(locked), 0);

    // Timeout while waiting for a selection.
    applyStimulus(goodPin);
    tick();
    checkOutput("sel_timeout_auth", 32'(authOk), 1);
    repeat (255) tick();
    checkOutput("sel_no_early_timeout", 32'(authOk), 1);
    tick();
    checkOutput("sel_timeout_err", 32'(err), 1);
    checkOutput("sel_timeout_auth_drop", 32'(authOk), 0);
    checkOutput("sel_timeout_no_vote", 32'(voteValid), 0);
    tick();

    // Ignored inputs: selection during PIN, keys during SEND and on the handshake cycle.
    pressKey(4'd1);
    pressKey(4'd2);
    selValid = 1'b1;
    selCand  = 2'd1;
    tick();
    selValid = 1'b0;
    checkOutput("sel_in_pin_no_auth", 32'(authOk), 0);
    pressKey(4'd3);
    pressKey(4'd4);
    tick();
    checkOutput("sel_in_pin_ignored", 32'(authOk), 1);
    voteReady = 1'b0;
    expQ.push_back(4'b0010);
    selectCand(2'd1);
    pressKey(4'd7);
    pressKey(4'd8);
    checkOutput("key_in_send_valid", 32'(voteValid), 1);
    checkOutput("key_in_send_onehot", 32'(voteOnehot), 32'h2);
    voteReady = 1'b1;
    keyValid  = 1'b1;
    keyDigit  = 4'd1;
    tick();
    keyValid = 1'b0;
    checkOutput("votes_after_third", 32'(votesCast), 3);
    applyStimulus(goodPin);
    tick();
    checkOutput("handshake_key_ignored", 32'(authOk), 1);

    // Out-of-range candidates on a five-candidate console.
    for (int i = 0; i < 4; i++) begin
      keyValidB = 1'b1;
      keyDigitB = goodPin[i*4 +: 4];
      tick();
    end
    keyValidB = 1'b0;
    tick();
    checkOutput("b_auth", 32'(authOkB), 1);
    selValidB = 1'b1;
    selCandB  = 3'd5;
    tick();
    selCandB = 3'd7;
    tick();
    selValidB = 1'b0;
    checkOutput("b_out_of_range_auth", 32'(authOkB), 1);
    checkOutput("b_out_of_range_no_vote", 32'(voteValidB), 0);
    expQB.push_back(5'b10000);
    selValidB = 1'b1;
    selCandB  = 3'd4;
    tick();
    selValidB = 1'b0;
    checkOutput("b_vote_valid", 32'(voteValidB), 1);
    checkOutput("b_vote_onehot", 32'(voteOnehotB), 32'h10);
    tick();
    checkOutput("b_votes_cast", 32'(votesCastB), 1);

    // Reset mid-SEND on the main console (still in SELECT from above).
    voteReady = 1'b0;
    selectCand(2'd3);
    checkOutput("pre_reset_valid", 32'(voteValid), 1);
    checkOutput("pre_reset_onehot", 32'(voteOnehot), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(voteValid), 0);
    checkOutput("async_rst_onehot", 32'(voteOnehot), 0);
    checkOutput("async_rst_auth", 32'(authOk), 0);
    checkOutput("async_rst_votes", 32'(votesCast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    voteReady = 1'b1;
    tick();

    // Saturating vote counter.
    for (int i = 0; i < 256; i++) begin
      doVote(2'(i % 4));
      if (i == 254) checkOutput("votes_255", 32'(votesCast), 255);
    end
    checkOutput("votes_saturated", 32'(votesCast), 255);
    tick();
    checkOutput("scoreboard_drained", 32'(expQ.size() + expQB.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
